// File: rtl/sdivmod_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdivmod_pkg
// Description : Shared constants for the iterative signed divider: default
//               operand width and the FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sdivmod_pkg;

    localparam int DEFAULT_DATAWIDTH = 64;

    // FSM state encoding
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_calc = 2'd1;
    localparam logic [1:0] c_st_sign = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

endpackage : sdivmod_pkg
`default_nettype wire

// File: rtl/sdivmod_step.sv
`default_nettype none
// ============================================================================
// Module      : sdivmod_step
// Description : One combinational restoring-division step. Shifts the next
//               dividend bit into the partial remainder and subtracts the
//               divisor magnitude when it fits.
// Revision    : 1.0 - initial release
// ============================================================================
module sdivmod_step
    import sdivmod_pkg::*;
#(
    parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) (
    input  logic [DATAWIDTH:0]   i_rem,
    input  logic                 i_bit,
    input  logic [DATAWIDTH-1:0] i_divisor,
    output logic [DATAWIDTH:0]   o_rem,
    output logic                 o_qbit
);

    logic [DATAWIDTH+1:0] w_shift;
    logic [DATAWIDTH:0]   w_diff;

    // Shifted remainder is kept one bit wider than the stored remainder so the
    // comparison sees every bit; the stored remainder never exceeds the divisor.
    assign w_shift = {i_rem, i_bit};
    assign o_qbit  = (w_shift >= {2'b00, i_divisor});
    assign w_diff  = w_shift[DATAWIDTH:0] - {1'b0, i_divisor};
    assign o_rem   = o_qbit ? w_diff : w_shift[DATAWIDTH:0];

endmodule : sdivmod_step
`default_nettype wire

// File: rtl/seq_sdivmod.sv
`default_nettype none
// ============================================================================
// Module      : seq_sdivmod
// Description : Multi-cycle signed divider (radix-2 restoring) producing
//               quotient and remainder with valid/ready handshakes. Divide by
//               zero and MIN/-1 are resolved at acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_sdivmod
    import sdivmod_pkg::*;
#(
    parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [DATAWIDTH-1:0] a,
    input  logic signed [DATAWIDTH-1:0] b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [DATAWIDTH-1:0] q,
    output logic signed [DATAWIDTH-1:0] r,
    output logic                        r_zero,
    output logic                        div_zero
);

    localparam int                   c_cnt_w = $clog2(DATAWIDTH + 1);
    localparam logic [DATAWIDTH-1:0] c_min   = {1'b1, {(DATAWIDTH-1){1'b0}}};
    localparam logic [DATAWIDTH-1:0] c_one   = {{(DATAWIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [DATAWIDTH-1:0] r_dvd;
    logic [DATAWIDTH-1:0] r_dvs;
    logic [DATAWIDTH:0]   r_rem;
    logic [DATAWIDTH-1:0] r_quot;
    logic                 r_sa;
    logic                 r_sb;
    logic                 r_out_valid;
    logic [DATAWIDTH-1:0] r_q;
    logic [DATAWIDTH-1:0] r_r;
    logic                 r_rz;
    logic                 r_dz;

    logic [DATAWIDTH-1:0] w_a_abs;
    logic [DATAWIDTH-1:0] w_b_abs;
    logic                 w_b_zero;
    logic                 w_ovf;
    logic [DATAWIDTH:0]   w_step_rem;
    logic                 w_step_q;
    logic [DATAWIDTH-1:0] w_q_fix;
    logic [DATAWIDTH-1:0] w_r_fix;

    // |MIN| wraps to MIN, which is the correct magnitude read as unsigned.
    assign w_a_abs  = a[DATAWIDTH-1] ? (~a + c_one) : a;
    assign w_b_abs  = b[DATAWIDTH-1] ? (~b + c_one) : b;
    assign w_b_zero = (b == '0);
    assign w_ovf    = (a == c_min) && (b == '1);

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign w_q_fix = (r_sa ^ r_sb) ? (~r_quot + c_one) : r_quot;
    assign w_r_fix = r_sa ? (~r_rem[DATAWIDTH-1:0] + c_one) : r_rem[DATAWIDTH-1:0];

    sdivmod_step #(
        .DATAWIDTH (DATAWIDTH)
    ) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_dvd[DATAWIDTH-1]),
        .i_divisor (r_dvs),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_q)
    );

    // Handshake flags come from registered state only.
    assign in_ready  = (r_state == c_st_idle);
    assign out_valid = r_out_valid;
    assign q         = r_q;
    assign r         = r_r;
    assign r_zero    = r_rz;
    assign div_zero  = r_dz;

    // Control FSM with iteration counter, operand and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_quot      <= '0;
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_out_valid <= 1'b0;
            r_q         <= '0;
            r_r         <= '0;
            r_rz        <= 1'b0;
            r_dz        <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid && in_ready) begin
                        r_sa   <= a[DATAWIDTH-1];
                        r_sb   <= b[DATAWIDTH-1];
                        r_dvd  <= w_a_abs;
                        r_dvs  <= w_b_abs;
                        r_cnt  <= c_cnt_w'(DATAWIDTH);
                        r_rem  <= '0;
                        r_quot <= '0;
                        if (w_b_zero) begin
                            r_q     <= '1;
                            r_r     <= a;
                            r_rz    <= (a == '0);
                            r_dz    <= 1'b1;
                            r_state <= c_st_done;
                        end else if (w_ovf) begin
                            r_q     <= c_min;
                            r_r     <= '0;
                            r_rz    <= 1'b1;
                            r_dz    <= 1'b0;
                            r_state <= c_st_done;
                        end else begin
                            r_dz    <= 1'b0;
                            r_state <= c_st_calc;
                        end
                    end
                end
                c_st_calc: begin
                    r_rem  <= w_step_rem;
                    r_quot <= {r_quot[DATAWIDTH-2:0], w_step_q};
                    r_dvd  <= {r_dvd[DATAWIDTH-2:0], 1'b0};
                    r_cnt  <= r_cnt - c_cnt_w'(1);
                    if (r_cnt == c_cnt_w'(1)) begin
                        r_state <= c_st_sign;
                    end
                end
                c_st_sign: begin
                    r_q     <= w_q_fix;
                    r_r     <= w_r_fix;
                    r_rz    <= (r_rem[DATAWIDTH-1:0] == '0);
                    r_state <= c_st_done;
                end
                c_st_done: begin
                    // Results settle on DONE entry; valid follows one cycle later.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule : seq_sdivmod
`default_nettype wire

// File: tb/tb_seq_sdivmod.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_sdivmod
// Description : Self-checking bench for seq_sdivmod with a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_sdivmod;

    localparam int W = 64;
    localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] q;
    logic signed [W-1:0] r;
    logic                r_zero;
    logic                div_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         rz;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    seq_sdivmod #(
        .DATAWIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
        .r_zero    (r_zero),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input exp_t e);
        chk("q", W'(q), e.q);
        chk("r", W'(r), e.r);
        chk("r_zero", W'(r_zero), W'(e.rz));
        chk("div_zero", W'(div_zero), W'(e.dz));
    endtask

    // One transaction: optional idle gap, offer operands, push expectation on
    // acceptance, pop and compare when the result appears, then hand shake.
    task automatic txn(input logic signed [W-1:0] ta, input logic signed [W-1:0] tb,
                       input logic signed [W-1:0] eq, input logic signed [W-1:0] er,
                       input logic edz, input int exp_lat, input int hold, input int gap);
        exp_t e;
        int   lat;
        int   wt;
        e.q  = eq;
        e.r  = er;
        e.rz = (er == 0);
        e.dz = edz;
        repeat (gap) tick();
        out_ready = (hold == 0);
        a         = ta;
        b         = tb;
        in_valid  = 1'b1;
        wt = 0;
        while (!in_ready && wt < 10) begin
            tick();
            wt++;
        end
        chk("in_ready_before_accept", W'(in_ready), W'(1));
        tick();
        in_valid = 1'b0;
        a        = ~ta;
        b        = ~tb;
        sb.push_back(e);
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        chk("latency", W'(lat), W'(exp_lat));
        e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            chk_out(e);
            chk("in_ready_held", W'(in_ready), W'(0));
            chk("out_valid_held", W'(out_valid), W'(1));
            tick();
        end
        chk_out(e);
        out_ready = 1'b1;
        tick();
        chk("in_ready_after_hs", W'(in_ready), W'(1));
        chk("out_valid_after_hs", W'(out_valid), W'(0));
    endtask

    function automatic logic signed [W-1:0] pick();
        logic signed [W-1:0] v;
        case ($urandom_range(0, 6))
            0:       v = MINV;
            1:       v = MAXV;
            2:       v = 1;
            3:       v = -1;
            4:       v = {$urandom(), $urandom()};
            5:       v = W'($urandom_range(0, 1000));
            default: begin
                v = W'($urandom_range(1, 1000));
                v = -v;
            end
        endcase
        return v;
    endfunction

    initial begin
        logic signed [W-1:0] ra;
        logic signed [W-1:0] rb;
        logic                seen;

        // Reset, with operands offered during reset to confirm they are ignored
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a         = 64'sd55;
        b         = 64'sd5;
        tick();
        tick();
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_q", W'(q), W'(0));
        chk("rst_r", W'(r), W'(0));
        chk("rst_r_zero", W'(r_zero), W'(0));
        chk("rst_div_zero", W'(div_zero), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();

        // Sign combinations and exact division
        txn(100, 7, 14, 2, 1'b0, W + 2, 0, 0);
        txn(-100, 7, -14, -2, 1'b0, W + 2, 0, 1);
        txn(100, -7, -14, 2, 1'b0, W + 2, 0, 1);
        txn(-100, -7, 14, -2, 1'b0, W + 2, 0, 2);
        txn(42, 6, 7, 0, 1'b0, W + 2, 0, 1);
        txn(0, 5, 0, 0, 1'b0, W + 2, 0, 1);

        // Corner cases resolved at acceptance
        txn(123, 0, -1, 123, 1'b1, 1, 0, 1);
        txn(0, 0, -1, 0, 1'b1, 1, 0, 1);
        txn(MINV, -1, MINV, 0, 1'b0, 1, 0, 1);

        // Backpressure then a follow-up pair
        txn(1000, -33, -30, 10, 1'b0, W + 2, 20, 1);
        txn(77, 10, 7, 7, 1'b0, W + 2, 0, 1);

        // Reset in the middle of CALC
        tick();
        a        = 1000;
        b        = 3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (30) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", W'(out_valid), W'(0));
        chk("midrst_q", W'(q), W'(0));
        chk("midrst_r", W'(r), W'(0));
        chk("midrst_in_ready", W'(in_ready), W'(1));
        seen = 1'b0;
        repeat (80) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("no_stale_result", W'(seen), W'(0));
        txn(-9, 4, -2, -1, 1'b0, W + 2, 0, 0);

        // Randomized pairs with random gaps and backpressure
        for (int n = 0; n < 24; n++) begin
            ra = pick();
            rb = pick();
            while (rb == 0 || (ra == MINV && rb == -1)) rb = pick();
            txn(ra, rb, ra / rb, ra % rb, 1'b0, W + 2,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_seq_sdivmod
`default_nettype wire

// File: doc/seq_sdivmod.md
# seq_sdivmod

Multi-cycle signed divider that produces quotient and remainder of one dividend/divisor pair per transaction, with valid/ready handshakes on both sides. It sits directly upstream of the datapath stage that compares the remainder against zero, muxes on the result and registers the final output. It replaces a pair of wide combinational divide/modulo units with one iterative radix-2 engine. Output semantics match Verilog signed `/` and `%` on the same operands, except at the two defined corner cases.

## Interface
- `DATAWIDTH`, 64, operand/result width in bits (≥2)
- `clk` input 1, rising-edge clock
- `rst` input 1, reset; synchronous, active-high
- `in_valid` input 1, operand pair offered
- `in_ready` output 1, block can accept an operand pair
- `a` input DATAWIDTH signed, dividend
- `b` input DATAWIDTH signed, divisor
- `out_valid` output 1, result held on outputs
- `out_ready` input 1, consumer takes the result
- `q` output DATAWIDTH signed, quotient
- `r` output DATAWIDTH signed, remainder
- `r_zero` output 1, remainder equals zero
- `div_zero` output 1, divisor was zero

## Operation
- States: IDLE, CALC, SIGN, DONE.
- IDLE: `in_ready`=1. Accept when `in_valid && in_ready`; latch |a|, |b|, sign(a), sign(b) and the iteration counter (DATAWIDTH).
  - If b==0: go to DONE with q = all ones (-1), r = a, `div_zero`=1.
  - If a==MIN and b==-1: go to DONE with q = MIN, r = 0.
  - Otherwise: go to CALC.
- CALC: restoring division, one quotient bit per cycle, MSB first. The partial remainder is DATAWIDTH+1 bits, so there is no overflow on |MIN|. Decrement the counter each cycle; go to SIGN after the DATAWIDTH-th step.
- SIGN: apply signs.
  - q is negated iff sign(a) != sign(b); this truncates toward zero.
  - r is negated iff sign(a)=1; the remainder takes the dividend's sign.
  - Compute `r_zero` from the final r. Go to DONE.
- DONE: `out_valid`=1. q, r, `r_zero`, `div_zero` are held stable until `out_valid && out_ready`, then the block returns to IDLE.
- No new operands are accepted in DONE. One transaction is in flight at a time.
- `r_zero` is valid on every result, including both corner cases.

## Timing
- Reset (first rising edge with `rst`=1): state=IDLE, `out_valid`=0, q=0, r=0, `r_zero`=0, `div_zero`=0, counter=0. `in_ready` reads 1 from that edge onward.
- Reset mid-operation: the in-flight transaction is discarded with no output. Inputs sampled while `rst`=1 are ignored.
- Normal latency: `out_valid` rises DATAWIDTH+2 edges after the accepting edge. For DATAWIDTH=64 this is 66 cycles: 1 to DONE entry plus 64 CALC plus 1 SIGN.
- Corner-case latency: `out_valid` rises 1 edge after the accepting edge.
- Handshake:
  - `in_ready` and `out_valid` are decoded from registered state only, with no combinational path from `in_valid` or `out_ready`.
  - Once asserted, `out_valid` is deasserted only by a completed handshake or by reset.
- Throughput: the earliest next acceptance is the edge after the output handshake. A bubble of at least 1 cycle in IDLE is required; there is no same-cycle turnaround.
- `out_ready` held low: the result persists indefinitely and outputs do not change.

## Structure
- Shared package `sdivmod_pkg`: state encoding localparams (IDLE, CALC, SIGN, DONE) and the default DATAWIDTH.
- One sub-module, `sdivmod_step`: combinational single restoring step.
  - Inputs: partial remainder (DATAWIDTH+1), next dividend bit, |divisor|.
  - Outputs: new partial remainder and quotient bit.
  - It is instantiated once and used iteratively.
- Top module: FSM, counter, operand/result registers, sign fix-up.

## Test plan
- a=100, b=7, `out_ready`=1 → q=14, r=2, `r_zero`=0, `out_valid` exactly 66 cycles after acceptance; a=-100,b=7 → q=-14, r=-2; a=100,b=-7 → q=-14, r=2; a=-100,b=-7 → q=14, r=-2.
- a=42, b=6 → q=7, r=0, `r_zero`=1; a=0, b=5 → q=0, r=0, `r_zero`=1.
- a=123, b=0 → q=-1, r=123, `div_zero`=1, `out_valid` 1 cycle after acceptance; a=MIN, b=-1 → q=MIN, r=0, `r_zero`=1, 1-cycle latency.
- Backpressure: hold `out_ready`=0 for 20 cycles after `out_valid` → outputs stable and `in_ready`=0 throughout. Raise `out_ready` → handshake completes, `in_ready`=1 next cycle. A second pair is then accepted and correct.
- Assert `rst` for 1 cycle at CALC step 30 → next edge `out_valid`=0, q=r=0, `in_ready`=1; no stale result ever appears. A fresh pair (-9, 4) then yields q=-2, r=-1.
- Randomized pairs including MIN/MAX/±1 against Verilog signed `/` and `%` (excluding b=0 and MIN/-1), with random `in_valid`/`out_ready` gaps.
